// File: rtl/song_playback_ctrl_pkg.sv
// Shared types and defaults for the song playback sequencer.
// State encodings are visible on the debug port, so their values are fixed.
package song_playback_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int TICK_W = 20;
    localparam logic [TICK_W-1:0] TICK_CYCLES_DEF = 20'd1000000;

    // The progression timer runs while a note is being fetched or sounded.
    function automatic logic is_run_state(input state_t s);
        return (s == ST_LOAD) || (s == ST_PLAY);
    endfunction

endpackage

// File: rtl/song_playback_ctrl_tick_divider.sv
// Duration-tick divider: counts 0..TICK_CYCLES-1 while enabled and flags the wrap cycle.
// Clear wins over enable; a disabled counter holds its value.
module song_playback_ctrl_tick_divider
    import song_playback_ctrl_pkg::*;
#(
    parameter logic [TICK_W-1:0] TICK_CYCLES = TICK_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_wrap
);

    logic [TICK_W-1:0] r_cnt;
    logic              w_at_top;

    assign w_at_top = (r_cnt == TICK_CYCLES - 1'b1);
    assign o_wrap   = i_en & w_at_top;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_at_top ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/song_playback_ctrl.sv
// Song playback sequencer: walks the note ROM, times each note in duration ticks
// and drives play / reset_player / song_done for the progression timer.
module song_playback_ctrl
    import song_playback_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 7,
    parameter logic [ADDR_WIDTH-1:0] SONG_LEN    = 7'd100,
    parameter int                    DUR_WIDTH   = 6,
    parameter logic [TICK_W-1:0]     TICK_CYCLES = TICK_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  play_pause_btn,
    input  logic                  restart_btn,
    input  logic [DUR_WIDTH-1:0]  note_duration,
    output logic [ADDR_WIDTH-1:0] note_addr,
    output logic                  new_note,
    output logic                  play,
    output logic                  reset_player,
    output logic                  song_done,
    output logic [2:0]            state
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = SONG_LEN - 1'b1;
    localparam logic [DUR_WIDTH-1:0]  DUR_ONE   = DUR_WIDTH'(1);

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_note_addr, w_addr_nxt;
    logic [DUR_WIDTH-1:0]  r_dur_left, w_dur_nxt;
    logic                  r_new_note, w_new_note_nxt;
    logic                  r_reset_player, w_reset_player_nxt;
    logic                  r_song_done, w_song_done_nxt;
    logic                  r_play;
    logic                  w_tick_en, w_tick_clr, w_wrap;

    // A pause press freezes the tick count in that cycle so a coincident wrap is deferred, not lost.
    assign w_tick_en  = (r_state == ST_PLAY) & ~play_pause_btn;
    assign w_tick_clr = restart_btn | (r_state == ST_LOAD);

    song_playback_ctrl_tick_divider #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_div (
        .i_clk  (clk),
        .i_rst_n(rst),
        .i_en   (w_tick_en),
        .i_clr  (w_tick_clr),
        .o_wrap (w_wrap)
    );

    always_comb begin
        w_state_nxt        = r_state;
        w_addr_nxt         = r_note_addr;
        w_dur_nxt          = r_dur_left;
        w_new_note_nxt     = 1'b0;
        w_reset_player_nxt = 1'b0;
        w_song_done_nxt    = 1'b0;

        if (restart_btn) begin
            w_state_nxt        = ST_IDLE;
            w_addr_nxt         = '0;
            w_dur_nxt          = '0;
            w_reset_player_nxt = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (play_pause_btn) w_state_nxt = ST_LOAD;
                end
                ST_LOAD: begin
                    // A zero duration marks the end of the song.
                    if (note_duration == '0) begin
                        w_state_nxt     = ST_DONE;
                        w_song_done_nxt = 1'b1;
                    end else begin
                        w_dur_nxt      = note_duration;
                        w_new_note_nxt = 1'b1;
                        w_state_nxt    = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (play_pause_btn) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (w_wrap) begin
                        if (r_dur_left == DUR_ONE) begin
                            if (r_note_addr == LAST_ADDR) begin
                                w_state_nxt     = ST_DONE;
                                w_song_done_nxt = 1'b1;
                            end else begin
                                w_addr_nxt  = r_note_addr + 1'b1;
                                w_state_nxt = ST_LOAD;
                            end
                        end else begin
                            w_dur_nxt = r_dur_left - 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (play_pause_btn) w_state_nxt = ST_PLAY;
                end
                ST_DONE: begin
                    if (play_pause_btn) begin
                        w_reset_player_nxt = 1'b1;
                        w_addr_nxt         = '0;
                        w_state_nxt        = ST_LOAD;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_note_addr    <= '0;
            r_dur_left     <= '0;
            r_new_note     <= 1'b0;
            r_reset_player <= 1'b0;
            r_song_done    <= 1'b0;
            r_play         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_note_addr    <= w_addr_nxt;
            r_dur_left     <= w_dur_nxt;
            r_new_note     <= w_new_note_nxt;
            r_reset_player <= w_reset_player_nxt;
            r_song_done    <= w_song_done_nxt;
            r_play         <= is_run_state(w_state_nxt);
        end
    end

    assign note_addr    = r_note_addr;
    assign new_note     = r_new_note;
    assign play         = r_play;
    assign reset_player = r_reset_player;
    assign song_done    = r_song_done;
    assign state        = r_state;

endmodule

// File: tb/tb_song_playback_ctrl.sv
// Directed bench for song_playback_ctrl with a 3-note song, 4-cycle ticks and ROM {2,1,3}.
// A note scoreboard checks address at each note start and the number of PLAY cycles per note.
module tb_song_playback_ctrl;

    localparam int S_IDLE  = 0;
    localparam int S_LOAD  = 1;
    localparam int S_PLAY  = 2;
    localparam int S_PAUSE = 3;
    localparam int S_DONE  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       play_pause_btn = 1'b0;
    logic       restart_btn = 1'b0;
    logic [5:0] note_duration;
    logic [6:0] note_addr;
    logic       new_note, play, reset_player, song_done;
    logic [2:0] state;

    logic [5:0] rom [0:7];
    assign note_duration = rom[note_addr[2:0]];

    song_playback_ctrl #(
        .ADDR_WIDTH (7),
        .SONG_LEN   (7'd3),
        .DUR_WIDTH  (6),
        .TICK_CYCLES(20'd4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .play_pause_btn(play_pause_btn),
        .restart_btn   (restart_btn),
        .note_duration (note_duration),
        .note_addr     (note_addr),
        .new_note      (new_note),
        .play          (play),
        .reset_player  (reset_player),
        .song_done     (song_done),
        .state         (state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int exp_addr_q[$];
    int exp_len_q[$];
    int done_pulses = 0;
    int rp_pulses   = 0;
    int mon_active  = 0;
    int mon_cnt     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic press_pp();
        play_pause_btn = 1'b1;
        step();
        play_pause_btn = 1'b0;
    endtask

    task automatic wait_until(input string tag, input int st, input int addr,
                              input int budget, output int steps);
        logic found;
        found = 1'b0;
        steps = 0;
        while (!found && steps < budget) begin
            step();
            steps++;
            if (state == 3'(st) && note_addr == 7'(addr)) found = 1'b1;
        end
        check({"reach_", tag}, {31'd0, found}, 32'd1);
    endtask

    // Note scoreboard: address popped at each new_note, PLAY-cycle length popped when the note ends.
    always @(negedge clk) begin
        if (rst) begin
            if (song_done) done_pulses++;
            if (reset_player) rp_pulses++;
            if (new_note) begin
                check("sb_addr_avail", {31'd0, exp_addr_q.size() > 0}, 32'd1);
                if (exp_addr_q.size() > 0) check("note_addr_at_new_note", note_addr, exp_addr_q.pop_front());
                mon_active = 1;
                mon_cnt    = 0;
            end
            if (mon_active != 0) begin
                if (state == 3'(S_PLAY)) begin
                    mon_cnt++;
                end else if (state == 3'(S_LOAD) || state == 3'(S_DONE)) begin
                    check("sb_len_avail", {31'd0, exp_len_q.size() > 0}, 32'd1);
                    if (exp_len_q.size() > 0) check("note_play_cycles", mon_cnt, exp_len_q.pop_front());
                    mon_active = 0;
                end else if (state == 3'(S_IDLE)) begin
                    mon_active = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int steps;
        rom[0] = 6'd2; rom[1] = 6'd1; rom[2] = 6'd3;
        for (int i = 3; i < 8; i++) rom[i] = 6'd0;

        // 1. reset
        step(); step();
        check("rst_state", state, S_IDLE);
        check("rst_play", play, 0);
        step();
        rst = 1'b1;
        step(); step();
        check("idle_state", state, S_IDLE);
        check("idle_addr", note_addr, 0);
        check("idle_play", play, 0);
        check("idle_pulses", {new_note, reset_player, song_done}, 0);

        // 2/3. first full run
        exp_addr_q.push_back(0); exp_addr_q.push_back(1); exp_addr_q.push_back(2);
        exp_len_q.push_back(8);  exp_len_q.push_back(4);  exp_len_q.push_back(12);
        press_pp();
        check("start_load", state, S_LOAD);
        check("start_play", play, 1);
        step();
        check("first_play_state", state, S_PLAY);
        check("first_new_note", new_note, 1);
        for (int i = 0; i < 7; i++) step();
        check("n0_before_wrap_addr", note_addr, 0);
        check("n0_before_wrap_state", state, S_PLAY);
        step();
        check("n0_after_wrap_addr", note_addr, 1);
        check("n0_after_wrap_state", state, S_LOAD);
        wait_until("done_run1", S_DONE, 2, 40, steps);
        check("run1_cycles_to_done", steps, 18);
        check("run1_song_done", song_done, 1);
        check("run1_play", play, 0);
        step();
        check("run1_done_once", song_done, 0);
        check("run1_hold_addr", note_addr, 2);
        check("run1_hold_state", state, S_DONE);

        // 6. replay from DONE
        exp_addr_q.push_back(0); exp_addr_q.push_back(1); exp_addr_q.push_back(2);
        exp_len_q.push_back(8);  exp_len_q.push_back(4);  exp_len_q.push_back(12);
        press_pp();
        check("replay_rp", reset_player, 1);
        check("replay_state", state, S_LOAD);
        check("replay_addr", note_addr, 0);
        wait_until("done_replay", S_DONE, 2, 60, steps);
        check("replay_cycles_to_done", steps, 27);
        check("replay_song_done", song_done, 1);

        // 4. pause at tick 2 of note 1
        exp_addr_q.push_back(0); exp_addr_q.push_back(1); exp_addr_q.push_back(2);
        exp_len_q.push_back(8);  exp_len_q.push_back(5);  exp_len_q.push_back(12);
        press_pp();
        wait_until("n1_play", S_PLAY, 1, 30, steps);
        check("n1_start_cycles", steps, 10);
        step(); step();
        press_pp();
        for (int i = 0; i < 10; i++) begin
            check("pause_state", state, S_PAUSE);
            check("pause_play", play, 0);
            if (i < 9) step();
        end
        press_pp();
        check("resume_state", state, S_PLAY);
        check("resume_play", play, 1);
        wait_until("n1_end", S_LOAD, 2, 10, steps);
        check("resume_to_note_end", steps, 2);
        wait_until("done_pause_run", S_DONE, 2, 40, steps);
        check("pause_run_tail", steps, 13);

        // 5. restart overrides play_pause during note 1
        exp_addr_q.push_back(0); exp_addr_q.push_back(1);
        exp_len_q.push_back(8);
        press_pp();
        wait_until("n1_play_b", S_PLAY, 1, 30, steps);
        step();
        play_pause_btn = 1'b1;
        restart_btn    = 1'b1;
        step();
        play_pause_btn = 1'b0;
        restart_btn    = 1'b0;
        check("restart_rp", reset_player, 1);
        check("restart_state", state, S_IDLE);
        check("restart_addr", note_addr, 0);
        check("restart_play", play, 0);
        step();
        check("restart_rp_once", reset_player, 0);
        check("restart_stays_idle", state, S_IDLE);
        restart_btn = 1'b1;
        step();
        restart_btn = 1'b0;
        check("idle_restart_rp", reset_player, 1);
        check("idle_restart_state", state, S_IDLE);

        // 6b. end marker at address 1
        rom[1] = 6'd0;
        exp_addr_q.push_back(0);
        exp_len_q.push_back(8);
        press_pp();
        wait_until("done_marker", S_DONE, 1, 30, steps);
        check("marker_cycles", steps, 10);
        check("marker_song_done", song_done, 1);
        check("marker_play", play, 0);
        step();
        check("marker_done_once", song_done, 0);

        check("sb_addr_drained", exp_addr_q.size(), 0);
        check("sb_len_drained", exp_len_q.size(), 0);
        check("song_done_pulse_total", done_pulses, 4);
        check("reset_player_pulse_total", rp_pulses, 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
